// File: rtl/hilo_unit_if.sv
// rtl/hilo_unit_if.sv - HI/LO unit operation and result bundle
//
// Signals:
//   OpValid  HiLoOp/Product/RsData valid this cycle
//   HiLoOp   3-bit operation code from the instruction controller
//   Product  2*WIDTH multiply result {upper, lower}
//   RsData   rs register value for MTHI/MTLO
//   Hi, Lo   committed HI/LO registers
//   Busy     accumulate in flight, new ops are ignored
// Modports: master = upstream issuer, slave = hilo_unit.

interface hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic                 OpValid;
  logic [2:0]           HiLoOp;
  logic [2*WIDTH-1:0]   Product;
  logic [WIDTH-1:0]     RsData;
  logic [WIDTH-1:0]     Hi;
  logic [WIDTH-1:0]     Lo;
  logic                 Busy;

  modport master (
    output OpValid, HiLoOp, Product, RsData,
    input  Hi, Lo, Busy
  );

  modport slave (
    input  OpValid, HiLoOp, Product, RsData,
    output Hi, Lo, Busy
  );
endinterface

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - architectural HI/LO register pair with 2-cycle MADD/MSUB
//
// Ports:
//   Clk  rising-edge system clock
//   Rst  asynchronous active-low reset
//   bus  hilo_unit_if.slave: OpValid/HiLoOp/Product/RsData in, Hi/Lo/Busy out
//
// MADD/MSUB split the 64-bit accumulate across two edges: the first edge
// registers the low-half sum and its carry/borrow, the second commits both
// halves at once so no partial result is ever visible on Hi/Lo.

module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  hilo_unit_if.slave  bus
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_MADD = 3'd2;
  localparam logic [2:0] OP_MSUB = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACC_HI = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH:0]    lo_sum_q, lo_sum_d;   // bit WIDTH = carry (add) or borrow (sub)
  logic [WIDTH-1:0]  prod_hi_q, prod_hi_d;
  logic              sub_q, sub_d;

  logic              accept;
  logic [WIDTH-1:0]  prod_lo;
  logic [WIDTH-1:0]  cin;

  assign accept  = bus.OpValid && (state_q == IDLE);
  assign prod_lo = bus.Product[WIDTH-1:0];
  assign cin     = {{(WIDTH-1){1'b0}}, lo_sum_q[WIDTH]};

  // State and datapath registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      lo_sum_q  <= '0;
      prod_hi_q <= '0;
      sub_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      lo_sum_q  <= lo_sum_d;
      prod_hi_q <= prod_hi_d;
      sub_q     <= sub_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    lo_sum_d  = lo_sum_q;
    prod_hi_d = prod_hi_q;
    sub_d     = sub_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (bus.HiLoOp)
            OP_LOAD: begin
              hi_d = bus.Product[2*WIDTH-1:WIDTH];
              lo_d = prod_lo;
            end
            OP_MADD, OP_MSUB: begin
              // Zero-extended subtraction leaves bit WIDTH set exactly when
              // Lo < Product low half, so one bit serves as carry or borrow.
              if (bus.HiLoOp == OP_MSUB) begin
                lo_sum_d = {1'b0, lo_q} - {1'b0, prod_lo};
              end else begin
                lo_sum_d = {1'b0, lo_q} + {1'b0, prod_lo};
              end
              prod_hi_d = bus.Product[2*WIDTH-1:WIDTH];
              sub_d     = (bus.HiLoOp == OP_MSUB);
              state_d   = ACC_HI;
            end
            OP_MTHI: hi_d = bus.RsData;
            OP_MTLO: lo_d = bus.RsData;
            default: ;  // OP_NONE and reserved codes leave state untouched
          endcase
        end
      end
      ACC_HI: begin
        if (sub_q) begin
          hi_d = hi_q - prod_hi_q - cin;
        end else begin
          hi_d = hi_q + prod_hi_q + cin;
        end
        lo_d    = lo_sum_q[WIDTH-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.Busy = (state_q == ACC_HI);
    bus.Hi   = hi_q;
    bus.Lo   = lo_q;
  end

  logic unused_op_none;
  assign unused_op_none = (OP_NONE == 3'd0);

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed self-checking bench for hilo_unit

module tb_hilo_unit;

  localparam int WIDTH = 32;

  logic Clk;
  logic Rst;
  int   checks;
  int   errors;

  hilo_unit_if #(.WIDTH(WIDTH)) bus ();

  hilo_unit #(.WIDTH(WIDTH)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op for a single edge; returns 1 time unit after that edge.
  task automatic issue(input logic [2:0] op, input logic [63:0] prod, input logic [31:0] rs);
    bus.OpValid = 1'b1;
    bus.HiLoOp  = op;
    bus.Product = prod;
    bus.RsData  = rs;
    @(posedge Clk);
    #1;
    bus.OpValid = 1'b0;
    bus.HiLoOp  = 3'd0;
    bus.Product = '0;
    bus.RsData  = '0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_hl(input string tag, input logic [31:0] hi, input logic [31:0] lo, input logic busy);
    check({tag, "_hi"}, {32'd0, bus.Hi}, {32'd0, hi});
    check({tag, "_lo"}, {32'd0, bus.Lo}, {32'd0, lo});
    check({tag, "_busy"}, {63'd0, bus.Busy}, {63'd0, busy});
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    Rst         = 1'b0;
    bus.OpValid = 1'b0;
    bus.HiLoOp  = 3'd0;
    bus.Product = '0;
    bus.RsData  = '0;

    step();
    step();
    check_hl("reset", 32'h0, 32'h0, 1'b0);
    Rst = 1'b1;

    // Load product, then asynchronous reset mid-cycle
    issue(3'd1, 64'h12345678_9ABCDEF0, 32'h0);
    check_hl("load", 32'h12345678, 32'h9ABCDEF0, 1'b0);
    #2 Rst = 1'b0;
    #1 check_hl("async_rst", 32'h0, 32'h0, 1'b0);
    #1 Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_hl("idle_after_rst", 32'h0, 32'h0, 1'b0);
    end

    // Moves
    issue(3'd1, 64'h12345678_9ABCDEF0, 32'h0);
    issue(3'd4, 64'h0, 32'hDEADBEEF);
    check_hl("mthi", 32'hDEADBEEF, 32'h9ABCDEF0, 1'b0);
    issue(3'd5, 64'h0, 32'hCAFEF00D);
    check_hl("mtlo", 32'hDEADBEEF, 32'hCAFEF00D, 1'b0);

    // MADD carry out of the low half
    issue(3'd4, 64'h0, 32'h0);
    issue(3'd5, 64'h0, 32'hFFFFFFFF);
    issue(3'd2, 64'h00000000_00000001, 32'h0);
    check_hl("madd_busy", 32'h0, 32'hFFFFFFFF, 1'b1);
    step();
    check_hl("madd_carry", 32'h1, 32'h0, 1'b0);

    // MSUB borrow from 1:0
    issue(3'd3, 64'h1, 32'h0);
    check_hl("msub_busy", 32'h1, 32'h0, 1'b1);
    step();
    check_hl("msub_borrow", 32'h0, 32'hFFFFFFFF, 1'b0);

    // MSUB wrap from 0:0
    issue(3'd4, 64'h0, 32'h0);
    issue(3'd5, 64'h0, 32'h0);
    issue(3'd3, 64'h1, 32'h0);
    step();
    check_hl("msub_wrap", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

    // MADD wrap through the 64-bit boundary: 1_80000000 + FFFFFFFF_80000000
    issue(3'd1, 64'h00000001_80000000, 32'h0);
    issue(3'd2, 64'hFFFFFFFF_80000000, 32'h0);
    step();
    check_hl("madd_wrap", 32'h1, 32'h0, 1'b0);

    // Busy blocking and back-to-back accumulate
    issue(3'd1, 64'h0, 32'h0);
    issue(3'd2, 64'h5, 32'h0);
    issue(3'd4, 64'h0, 32'h77);   // lands during ACC_HI, must be ignored
    check_hl("busy_ignore", 32'h0, 32'h5, 1'b0);
    issue(3'd2, 64'h3, 32'h0);
    check_hl("b2b_busy", 32'h0, 32'h5, 1'b1);
    step();
    check_hl("b2b_sum", 32'h0, 32'h8, 1'b0);

    // Reset during ACC_HI aborts the accumulate
    issue(3'd2, 64'h00000010_00000020, 32'h0);
    check_hl("abort_busy", 32'h0, 32'h8, 1'b1);
    #2 Rst = 1'b0;
    #1 check_hl("abort_rst", 32'h0, 32'h0, 1'b0);
    #1 Rst = 1'b1;
    step();
    step();
    check_hl("abort_after", 32'h0, 32'h0, 1'b0);

    // Op 0 and reserved ops leave state alone
    issue(3'd1, 64'hAAAA5555_0F0F1234, 32'h0);
    issue(3'd0, 64'h11111111_22222222, 32'h33);
    check_hl("op0", 32'hAAAA5555, 32'h0F0F1234, 1'b0);
    issue(3'd6, 64'h11111111_22222222, 32'h33);
    check_hl("op6", 32'hAAAA5555, 32'h0F0F1234, 1'b0);
    issue(3'd7, 64'h11111111_22222222, 32'h33);
    check_hl("op7", 32'hAAAA5555, 32'h0F0F1234, 1'b0);

    // OpValid low with a live op code does nothing
    bus.HiLoOp  = 3'd1;
    bus.Product = 64'h99999999_88888888;
    step();
    check_hl("no_valid", 32'hAAAA5555, 32'h0F0F1234, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
